// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: transmit (source-domain) end of a 4-phase req/ack CDC handshake.
// Captures one word per transfer, holds it on data_o while req_o is high, and
// synchronizes the remote ack_i through a SYNC_REGS-deep flop chain.
// Optional watchdog enabled by defining the macro CDC_HS_TX_TIMEOUT_EN; without
// it err_o is tied low and the FSM waits indefinitely for the destination.
module cdc_hs_tx #(
   parameter int DATA_W         = 8,
   parameter int SYNC_REGS      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              req_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              ack_i,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   // Reject illegal configurations at elaboration time.
   generate
      if (SYNC_REGS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
         $error("cdc_hs_tx: SYNC_REGS and TIMEOUT_CYCLES must both be >= 2");
      end
   endgenerate

   state_t              state;
   state_t              state_next;
   logic [SYNC_REGS-1:0] ack_sync;
   logic                ack_s;
   logic                req_next;
   logic                done_next;
   logic                err_next;
   logic                load;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             abort;
   logic             abort_next;
   logic             expired;

   assign expired = (cnt == CNT_LAST);
`endif

   // ack_i is asynchronous; only the last stage of the chain is used.
   assign ack_s   = ack_sync[SYNC_REGS-1];
   assign ready_o = (state == IDLE);

   // Synchronizer chain for the remote acknowledge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_REGS-2:0], ack_i};
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, wait for ack high in REQ, ack low in DROP.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (valid_i) state_next = REQ;
         end
         REQ: begin
            if (ack_s) begin
               state_next = DROP;
            end
`ifdef CDC_HS_TX_TIMEOUT_EN
            else if (expired) begin
               state_next = DROP;
            end
`endif
         end
         DROP: begin
            // Never leave DROP while the destination still holds ack.
            if (!ack_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values for the registered req/done/err/data outputs.
   always_comb begin
      req_next   = req_o;
      done_next  = 1'b0;
      err_next   = 1'b0;
      load       = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
      cnt_next   = cnt;
      abort_next = abort;
`endif
      case (state)
         IDLE: begin
            if (valid_i) begin
               load     = 1'b1;
               req_next = 1'b1;
`ifdef CDC_HS_TX_TIMEOUT_EN
               cnt_next = '0;
`endif
            end
         end
         REQ: begin
            if (ack_s) begin
               req_next = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
               cnt_next = '0;
`endif
            end
`ifdef CDC_HS_TX_TIMEOUT_EN
            else if (expired) begin
               // Give up on the destination: withdraw req and remember the abort.
               req_next   = 1'b0;
               abort_next = 1'b1;
               err_next   = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
`endif
         end
         DROP: begin
            if (!ack_s) begin
`ifdef CDC_HS_TX_TIMEOUT_EN
               done_next  = !abort;
               abort_next = 1'b0;
`else
               done_next  = 1'b1;
`endif
            end
`ifdef CDC_HS_TX_TIMEOUT_EN
            else if (expired) begin
               // Ack stuck high: report periodically but keep waiting.
               err_next = 1'b1;
               cnt_next = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
`endif
         end
         default: begin
            req_next = 1'b0;
         end
      endcase
   end

   // Registered outputs so req_o is glitch-free toward the other domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_o  <= 1'b0;
         done_o <= 1'b0;
         data_o <= '0;
      end else begin
         req_o  <= req_next;
         done_o <= done_next;
         if (load) data_o <= data_i;
      end
   end

`ifdef CDC_HS_TX_TIMEOUT_EN
   // Watchdog counter, abort flag and error pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt   <= '0;
         abort <= 1'b0;
         err_o <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         abort <= abort_next;
         err_o <= err_next;
      end
   end
`else
   assign err_o = 1'b0;
   // err_next only carries information when the watchdog is built in.
   logic unused_err;
   assign unused_err = err_next;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: scoreboard bench for cdc_hs_tx. A driver pushes each issued word
// into a queue; a monitor pops on every req_o rising edge and checks data,
// handshake latencies and done/err pulses against the handshake rules.
module tb_cdc_hs_tx;
   localparam int DATA_W    = 8;
   localparam int SYNC_REGS = 2;
   localparam int TO        = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              ack = 1'b0;
   logic              ready;
   logic              req;
   logic [DATA_W-1:0] dout;
   logic              done;
   logic              err;

   cdc_hs_tx #(
      .DATA_W(DATA_W),
      .SYNC_REGS(SYNC_REGS),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .valid_i(valid),
      .data_i(din),
      .ready_o(ready),
      .req_o(req),
      .data_o(dout),
      .ack_i(ack),
      .done_o(done),
      .err_o(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int total = 0;
   int bad = 0;
   int exp_done = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit auto_ack = 1'b0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
      end
   endtask

   // Issue one word; returns just after the accepting edge. hold keeps valid high.
   task automatic send(input logic [DATA_W-1:0] w, input bit hold);
      int n = 0;
      valid = 1'b1;
      din   = w;
      exp_q.push_back(w);
      while (!ready && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      check("accept_within_budget", ready, 1);
      @(negedge clk); #1;
      if (!hold) valid = 1'b0;
      $display("send 0x%02h accepted at cycle %0d", w, cyc);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic wait_req(input logic level);
      int n = 0;
      while (req !== level && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("req_reaches_level", req, level);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt < exp_done && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      check("done_within_budget", done_cnt, exp_done);
   endtask

   task automatic manual_ack();
      ack = 1'b1;
      wait_req(1'b0);
      ack = 1'b0;
      wait_done();
   endtask

   // Destination model: raises ack some cycles after seeing req, drops it once req falls.
   initial begin
      int d = 0;
      bit pend = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (auto_ack) begin
            if (req && !ack) begin
               if (!pend) begin
                  pend = 1'b1;
                  d = $urandom_range(0, 3);
               end
               if (d == 0) begin
                  ack = 1'b1;
                  pend = 1'b0;
               end else begin
                  d--;
               end
            end else if (!req && ack) begin
               ack = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each new request and checks handshake rules.
   initial begin
      logic p_req = 1'b0;
      logic p_ack = 1'b0;
      logic [DATA_W-1:0] cap = '0;
      logic [DATA_W-1:0] e;
      int rise_cyc = 0;
      int fall_cyc = 0;
      bit rise_v = 1'b0;
      bit fall_v = 1'b0;
      bit in_flight = 1'b0;
      bit aborted = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_flight = 1'b0;
            aborted = 1'b0;
            rise_v = 1'b0;
            fall_v = 1'b0;
            p_req = req;
            p_ack = ack;
         end else begin
            if (ack && !p_ack && req) begin
               rise_cyc = cyc;
               rise_v = 1'b1;
            end
            if (!ack && p_ack && in_flight && !req) begin
               fall_cyc = cyc;
               fall_v = 1'b1;
            end
            if (req && !p_req) begin
               check("one_in_flight", in_flight, 0);
               check("req_matches_send", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("data_on_accept", dout, e);
                  $display("req rise data 0x%02h expected 0x%02h cycle %0d", dout, e, cyc);
               end
               in_flight = 1'b1;
               aborted = 1'b0;
               rise_v = 1'b0;
               fall_v = 1'b0;
               cap = dout;
            end else if (req && p_req) begin
               check("data_stable_while_req", dout, cap);
            end
            if (!req && p_req && rise_v) begin
               check("req_fall_latency", cyc - rise_cyc, SYNC_REGS);
               rise_v = 1'b0;
            end
            if (err) begin
               err_cnt++;
               if (p_req && !req) aborted = 1'b1;
               $display("err pulse at cycle %0d", cyc);
            end
            if (done) begin
               done_cnt++;
               check("done_expected", in_flight && !aborted, 1);
               if (fall_v) check("done_latency", cyc - fall_cyc, SYNC_REGS);
               $display("done pulse for 0x%02h at cycle %0d", cap, cyc);
               in_flight = 1'b0;
               fall_v = 1'b0;
            end else if (ready && in_flight) begin
               check("idle_without_done_only_if_aborted", aborted, 1);
               in_flight = 1'b0;
               aborted = 1'b0;
            end
            p_req = req;
            p_ack = ack;
         end
      end
   end

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   // Stimulus sequence.
   initial begin
      logic [DATA_W-1:0] w;
      bit hold;
      int s;
      int n;

      // Reset state.
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_req", req, 0);
      check("rst_data", dout, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      #1 rst_n = 1'b1;
      wait_cycles(2);

      // Basic transfer with a manual ack three cycles after req.
      send(8'hA5, 1'b0);
      exp_done++;
      check("basic_req_high", req, 1);
      check("basic_data", dout, 8'hA5);
      wait_cycles(2);
      manual_ack();
      check("basic_ready_after_done", ready, 1);

      // Valid pulsed while busy must be ignored.
      send(8'h5A, 1'b0);
      exp_done++;
      valid = 1'b1;
      din = 8'hFF;
      wait_cycles(1);
      valid = 1'b0;
      wait_cycles(2);
      check("busy_data_kept", dout, 8'h5A);
      manual_ack();

      // Back-to-back with valid held high.
      auto_ack = 1'b1;
      exp_done += 2;
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      wait_done();

      // Randomized traffic with a randomly paced destination.
      for (int i = 0; i < 30; i++) begin
         w = DATA_W'($urandom);
         hold = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
         exp_done++;
         send(w, hold);
         if (!hold) wait_cycles($urandom_range(0, 3));
      end
      wait_done();
      wait_cycles(2);

      // Reset during REQ abandons the transfer.
      auto_ack = 1'b0;
      send(8'h99, 1'b0);
      check("mid_req_high", req, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_low", req, 0);
      check("mid_rst_data_zero", dout, 0);
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(3);
      check("mid_rst_ready", ready, 1);
      check("mid_rst_no_done", done_cnt, exp_done);

`ifdef CDC_HS_TX_TIMEOUT_EN
      // Timeout in REQ: destination never acks.
      send(8'h3C, 1'b0);
      s = cyc;
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("req_timeout_cycle", cyc - s, TO);
      check("req_dropped_on_timeout", req, 0);
      wait_cycles(1);
      check("idle_after_abort", ready, 1);
      auto_ack = 1'b1;
      exp_done++;
      send(8'hC3, 1'b0);
      wait_done();
      wait_cycles(2);

      // Timeout in DROP: ack stuck high after req falls.
      auto_ack = 1'b0;
      exp_done++;
      send(8'h77, 1'b0);
      ack = 1'b1;
      wait_req(1'b0);
      s = cyc;
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("drop_timeout_first", cyc - s, TO);
      wait_cycles(1);
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("drop_timeout_second", cyc - s, 2 * TO);
      check("drop_stays_busy", ready, 0);
      ack = 1'b0;
      wait_done();
      check("drop_ready_after_release", ready, 1);
`endif

      wait_cycles(4);
      check("final_done_count", done_cnt, exp_done);
      check("final_queue_empty", exp_q.size(), 0);
`ifdef CDC_HS_TX_TIMEOUT_EN
      check("final_err_count", err_cnt, 3);
`else
      check("final_err_count", err_cnt, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
